// File: rtl/vend_accum.sv
// vend_accum: sequential front end of the vending datapath.
// Accumulates coins and the current selection, feeds the downstream
// change/dispense stage, and latches its results with a one-cycle vend pulse.
// Optional feature: define VEND_TIMEOUT_EN to auto-cancel after TMO_CYC idle
// cycles in INSERT.
module vend_accum #(
  parameter int DW      = 8,
  parameter int TMO_CYC = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coin_valid,
  input  logic [DW-1:0] coin_val,
  input  logic          sel_valid,
  input  logic [DW-1:0] unit_price,
  input  logic [DW-1:0] sel_count,
  input  logic          buy,
  input  logic          cancel,
  input  logic [DW-1:0] dd_out_count,
  input  logic [DW-1:0] dd_change,
  output logic [DW-1:0] total_insert,
  output logic [DW-1:0] total_price,
  output logic [DW-1:0] input_count,
  output logic          vend,
  output logic [DW-1:0] dispense_cnt,
  output logic [DW-1:0] change_out,
  output logic          busy
);

  // Downstream treats the difference MSB as a sign, so values stay below it.
  localparam logic [DW-1:0]   MAXV   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW:0]     MAXV_S = {1'b0, MAXV};
  localparam logic [2*DW-1:0] MAXV_P = {{DW{1'b0}}, MAXV};

  typedef enum logic [1:0] {IDLE, INSERT, SETTLE, VEND} state_t;

  state_t          state;
  logic            has_sel;
  logic [DW:0]     coin_sum;
  logic [DW-1:0]   sat_insert;
  logic [2*DW-1:0] price_prod;
  logic [DW-1:0]   sat_price;
  logic            tmo_hit;
  logic            cancel_eff;
  logic            buy_ok;

  // Saturating coin sum and clamped price product.
  always_comb begin
    coin_sum   = {1'b0, total_insert} + {1'b0, coin_val};
    sat_insert = (coin_sum > MAXV_S) ? MAXV : coin_sum[DW-1:0];
    price_prod = {{DW{1'b0}}, unit_price} * {{DW{1'b0}}, sel_count};
    sat_price  = (price_prod > MAXV_P) ? MAXV : price_prod[DW-1:0];
  end

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC) + 1;
  logic [TW-1:0] tmo_cnt;
  logic          ins_quiet;

  assign ins_quiet = (state == INSERT) && !(coin_valid || sel_valid || buy || cancel);
  assign tmo_hit   = ins_quiet && (tmo_cnt == TW'(TMO_CYC - 1));

  // Idle-cycle counter; any activity or leaving INSERT returns it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (ins_quiet && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign cancel_eff = cancel || tmo_hit;
  // A selection arriving with buy counts as existing.
  assign buy_ok     = buy && (has_sel || sel_valid);

  // Main FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      has_sel      <= 1'b0;
      total_insert <= '0;
      total_price  <= '0;
      input_count  <= '0;
      vend         <= 1'b0;
      dispense_cnt <= '0;
      change_out   <= '0;
      busy         <= 1'b0;
    end else begin
      vend <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_valid) total_insert <= sat_insert;
          if (sel_valid) begin
            total_price <= sat_price;
            input_count <= sel_count;
            has_sel     <= 1'b1;
          end
          if (coin_valid || sel_valid) state <= INSERT;
        end
        INSERT: begin
          if (coin_valid) total_insert <= sat_insert;
          if (sel_valid) begin
            total_price <= sat_price;
            input_count <= sel_count;
            has_sel     <= 1'b1;
          end
          // Cancel overrides any selection written above so diffdev refunds all.
          if (cancel_eff) begin
            total_price <= MAXV;
            input_count <= '0;
            busy        <= 1'b1;
            state       <= SETTLE;
          end else if (buy_ok) begin
            busy  <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          dispense_cnt <= dd_out_count;
          change_out   <= dd_change;
          vend         <= 1'b1;
          total_insert <= '0;
          total_price  <= '0;
          input_count  <= '0;
          has_sel      <= 1'b0;
          state        <= VEND;
        end
        VEND: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
